bcd_rtc_clock: RTL and testbench
================================

Name: bcd_rtc_clock

Overview:
Parametrised successor of the team's BCD 12-hour clock. Keeps time internally in 24-hour BCD and presents hours in either 12-hour (with pm) or 24-hour format, selected at run time. Adds a cycle prescaler for the seconds tick, a validated time-set port and one hh:mm alarm with a sticky interrupt. Sits between the board clock domain and display/CPU logic.

Parameters:
TICK_DIV, 1, clk cycles (with ena high) per one-second advance; must be >= 1; prescaler width = clog2(TICK_DIV), minimum 1.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ena  in  1  count enable; prescaler and time hold while low
mode_24h  in  1  1 = 24-hour display, 0 = 12-hour display
set_valid  in  1  load set_time this cycle
set_time  in  24  {hh,mm,ss} BCD, 24-hour format
alarm_wr  in  1  load alarm_hhmm this cycle
alarm_hhmm  in  16  {hh,mm} BCD, 24-hour format
alarm_en  in  1  alarm compare enable
alarm_ack  in  1  clears alarm_irq
hh  out  8  BCD hours, display format
mm  out  8  BCD minutes
ss  out  8  BCD seconds
pm  out  1  1 when internal hour >= 12 (both modes)
sec_pulse  out  1  one-cycle pulse on each seconds advance
set_err  out  1  one-cycle pulse on rejected set_valid/alarm_wr
alarm_irq  out  1  sticky alarm flag

Behaviour:
- Reset (synchronous, highest priority): internal time 00:00:00, alarm reg 00:00, prescaler 0, sec_pulse=0, set_err=0, alarm_irq=0. Display outputs registered from reset time: mode_24h=0 -> hh=8'h12, pm=0; mode_24h=1 -> hh=8'h00, pm=0; mm=ss=8'h00.
- All outputs are registered; a tick, set or mode change is visible on outputs the cycle after the edge that sampled it.
- Prescaler: increments when ena=1; when count==TICK_DIV-1 and ena=1 -> tick, count returns to 0. ena=0 holds count. TICK_DIV=1 -> tick every enabled cycle.
- Tick: ss+1 in BCD; 59->00 carries to mm; mm 59->00 carries to hh; hh 23->00. Each digit wraps 9->0 with carry; no non-BCD value ever reachable. sec_pulse=1 on the same edge the time updates.
- Display conversion (12h): internal 00 -> 12 pm=0; 01-11 -> same pm=0; 12 -> 12 pm=1; 13-23 -> hh-12 in BCD, pm=1. 24h: hh = internal. Changing mode_24h never alters internal time.
- Set: set_valid=1 with valid BCD (every digit <=9, hh<=23, mm<=59, ss<=59) -> time loaded, prescaler cleared to 0, no sec_pulse that cycle. Invalid -> time unchanged, set_err pulses 1 cycle. Priority: reset > set > tick; a tick coinciding with set is discarded.
- Alarm write: alarm_wr with valid hh<=23, mm<=59 -> alarm reg loaded; invalid -> ignored, set_err pulses. set_valid and alarm_wr may coincide; each is validated independently, set_err pulses if either is rejected.
- Alarm fire: only on a tick that advances time to exactly {alarm_hh, alarm_mm, 00} with alarm_en=1 -> alarm_irq=1 on the same edge. A set landing on the alarm time does not fire. alarm_irq holds until alarm_ack; ack and new fire in the same cycle -> alarm_irq stays 1.

Test Plan:
- Reset with mode_24h=0 -> hh=12, mm=00, ss=00, pm=0; with mode_24h=1 -> hh=00; all flags 0.
- TICK_DIV=4, ena toggled 1,1,0,1,1 -> sec_pulse only on the 4th enabled cycle; ss 00->01.
- Set 11:59:59, mode 12h, one tick -> 12:00:00 pm=1; set 23:59:59, tick -> 12:00:00 pm=0 (12h) / 00:00:00 (24h); 13:05:00 displays 01 pm=1.
- set_time=24:00:00 or 12:5A:00 -> set_err pulse, time unchanged; alarm_hhmm=12:60 -> set_err, alarm unchanged.
- Alarm 07:30, time set 07:29:59, alarm_en=1, tick -> alarm_irq=1 held; alarm_ack -> 0; set directly to 07:30:00 -> no fire; alarm_en=0 -> no fire.
- set_valid coincident with tick -> loaded value shown, no sec_pulse; reset during counting -> reset values next cycle regardless of set_valid.

Source files
------------

// File: rtl/bcd_rtc_clock_if.sv
// Control/status bundle of the BCD real-time clock: run/set/alarm controls in,
// display time and event flags out.
interface bcd_rtc_clock_if;
  logic        ena;
  logic        mode_24h;
  logic        set_valid;
  logic [23:0] set_time;
  logic        alarm_wr;
  logic [15:0] alarm_hhmm;
  logic        alarm_en;
  logic        alarm_ack;
  logic [7:0]  hh;
  logic [7:0]  mm;
  logic [7:0]  ss;
  logic        pm;
  logic        sec_pulse;
  logic        set_err;
  logic        alarm_irq;

  modport master (
    output ena, mode_24h, set_valid, set_time, alarm_wr, alarm_hhmm, alarm_en, alarm_ack,
    input  hh, mm, ss, pm, sec_pulse, set_err, alarm_irq
  );

  modport slave (
    input  ena, mode_24h, set_valid, set_time, alarm_wr, alarm_hhmm, alarm_en, alarm_ack,
    output hh, mm, ss, pm, sec_pulse, set_err, alarm_irq
  );
endinterface

// File: rtl/bcd_rtc_clock.sv
// BCD real-time clock: 24-hour internal time, 12/24-hour display, seconds
// prescaler, validated time set and one hh:mm alarm with sticky interrupt.
module bcd_rtc_clock #(
  parameter int unsigned TICK_DIV = 1
) (
  input logic             clk,
  input logic             reset,
  bcd_rtc_clock_if.slave  bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TW = 24;
  localparam int unsigned AW = 16;

  logic [PW-1:0] pre_q, pre_d;
  logic [TW-1:0] time_q, time_d;
  logic [AW-1:0] alarm_q, alarm_d;

  logic [7:0] hh_q, mm_q, ss_q;
  logic       pm_q, sec_pulse_q, set_err_q, alarm_irq_q;

  logic tick_c, set_ok_c, alarm_ok_c, fire_c, reject_c;

  function automatic logic [7:0] bcd2bin(input logic [7:0] v);
    return 8'(v[7:4]) * 8'd10 + 8'(v[3:0]);
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [7:0] b);
    return {4'(b / 8'd10), 4'(b % 8'd10)};
  endfunction

  // Both digits decimal and the value within range.
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max_bin);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (bcd2bin(v) <= max_bin);
  endfunction

  // Two-digit BCD increment wrapping to 00 after 'last'.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    logic [7:0] r;
    if (v == last) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [TW-1:0] advance(input logic [TW-1:0] t);
    logic [7:0] h, m, s;
    h = t[23:16];
    m = t[15:8];
    s = bcd_inc(t[7:0], 8'h59);
    if (t[7:0] == 8'h59) begin
      m = bcd_inc(t[15:8], 8'h59);
      if (t[15:8] == 8'h59) begin
        h = bcd_inc(t[23:16], 8'h23);
      end
    end
    return {h, m, s};
  endfunction

  // Internal 00..23 hour to display hour; 12-hour mode maps 00 to 12.
  function automatic logic [7:0] disp_hour(input logic [7:0] h, input logic mode_24);
    logic [7:0] b;
    logic [7:0] r;
    b = bcd2bin(h);
    if (mode_24) begin
      r = h;
    end else if (b == 8'd0) begin
      r = 8'h12;
    end else if (b > 8'd12) begin
      r = bin2bcd(b - 8'd12);
    end else begin
      r = h;
    end
    return r;
  endfunction

  // Validation of host writes.
  always_comb begin
    set_ok_c   = 1'b0;
    alarm_ok_c = 1'b0;
    reject_c   = 1'b0;
    if (bus.set_valid) begin
      set_ok_c = bcd_ok(bus.set_time[23:16], 8'd23) &&
                 bcd_ok(bus.set_time[15:8],  8'd59) &&
                 bcd_ok(bus.set_time[7:0],   8'd59);
    end
    if (bus.alarm_wr) begin
      alarm_ok_c = bcd_ok(bus.alarm_hhmm[15:8], 8'd23) &&
                   bcd_ok(bus.alarm_hhmm[7:0],  8'd59);
    end
    reject_c = (bus.set_valid && !set_ok_c) || (bus.alarm_wr && !alarm_ok_c);
  end

  // Next time / prescaler / alarm; a valid set overrides a coincident tick.
  always_comb begin
    pre_d   = pre_q;
    time_d  = time_q;
    alarm_d = alarm_q;
    tick_c  = 1'b0;
    fire_c  = 1'b0;
    if (set_ok_c) begin
      time_d = bus.set_time;
      pre_d  = '0;
    end else if (bus.ena) begin
      if (pre_q == PW'(TICK_DIV - 1)) begin
        pre_d  = '0;
        tick_c = 1'b1;
        time_d = advance(time_q);
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
    fire_c = tick_c && bus.alarm_en && (time_d == {alarm_q, 8'h00});
    if (alarm_ok_c) begin
      alarm_d = bus.alarm_hhmm;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q       <= '0;
      time_q      <= '0;
      alarm_q     <= '0;
      hh_q        <= bus.mode_24h ? 8'h00 : 8'h12;
      mm_q        <= 8'h00;
      ss_q        <= 8'h00;
      pm_q        <= 1'b0;
      sec_pulse_q <= 1'b0;
      set_err_q   <= 1'b0;
      alarm_irq_q <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      time_q      <= time_d;
      alarm_q     <= alarm_d;
      hh_q        <= disp_hour(time_d[23:16], bus.mode_24h);
      mm_q        <= time_d[15:8];
      ss_q        <= time_d[7:0];
      pm_q        <= (bcd2bin(time_d[23:16]) >= 8'd12);
      sec_pulse_q <= tick_c;
      set_err_q   <= reject_c;
      alarm_irq_q <= fire_c | (alarm_irq_q & ~bus.alarm_ack);
    end
  end

  assign bus.hh        = hh_q;
  assign bus.mm        = mm_q;
  assign bus.ss        = ss_q;
  assign bus.pm        = pm_q;
  assign bus.sec_pulse = sec_pulse_q;
  assign bus.set_err   = set_err_q;
  assign bus.alarm_irq = alarm_irq_q;

endmodule

// File: tb/tb_bcd_rtc_clock.sv
// Scoreboard bench for bcd_rtc_clock: a seconds-of-day reference model predicts
// every cycle's outputs; a monitor compares them one clock edge later.
module tb_bcd_rtc_clock;
  localparam int unsigned TICK_DIV = 4;

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       pm;
    logic       sec_pulse;
    logic       set_err;
    logic       alarm_irq;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bcd_rtc_clock_if bus();

  bcd_rtc_clock #(.TICK_DIV(TICK_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Stimulus for the next cycle
  logic        r_reset, r_ena, r_mode, r_set_valid, r_alarm_wr, r_alarm_en, r_alarm_ack;
  logic [23:0] r_set_time;
  logic [15:0] r_alarm_hhmm;

  // Reference model: time as seconds of day, alarm as minute of day
  int m_tod, m_alarm, m_cnt;
  bit m_irq;

  obs_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;

  function automatic int dec2(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic bit ok2(input logic [7:0] v, input int maxv);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (dec2(v) <= maxv);
  endfunction

  function automatic logic [7:0] to_bcd(input int x);
    logic [7:0] r;
    r[7:4] = 4'(x / 10);
    r[3:0] = 4'(x % 10);
    return r;
  endfunction

  function automatic logic [23:0] t24(input int h, input int m, input int s);
    return {to_bcd(h), to_bcd(m), to_bcd(s)};
  endfunction

  task automatic clear_stim();
    r_reset = 1'b0; r_ena = 1'b0; r_set_valid = 1'b0; r_alarm_wr = 1'b0;
    r_alarm_ack = 1'b0; r_set_time = '0; r_alarm_hhmm = '0;
  endtask

  // Apply one cycle of stimulus, advance the model and queue the prediction.
  task automatic step();
    obs_t e;
    bit sv, av, pulse, err, fire;
    int h;
    @(negedge clk);
    reset          = r_reset;
    bus.ena        = r_ena;
    bus.mode_24h   = r_mode;
    bus.set_valid  = r_set_valid;
    bus.set_time   = r_set_time;
    bus.alarm_wr   = r_alarm_wr;
    bus.alarm_hhmm = r_alarm_hhmm;
    bus.alarm_en   = r_alarm_en;
    bus.alarm_ack  = r_alarm_ack;
    pulse = 1'b0; err = 1'b0; fire = 1'b0;
    if (r_reset) begin
      m_tod = 0; m_alarm = 0; m_cnt = 0; m_irq = 1'b0;
    end else begin
      sv = r_set_valid && ok2(r_set_time[23:16], 23) && ok2(r_set_time[15:8], 59) &&
           ok2(r_set_time[7:0], 59);
      av = r_alarm_wr && ok2(r_alarm_hhmm[15:8], 23) && ok2(r_alarm_hhmm[7:0], 59);
      err = (r_set_valid && !sv) || (r_alarm_wr && !av);
      if (sv) begin
        m_tod = dec2(r_set_time[23:16]) * 3600 + dec2(r_set_time[15:8]) * 60 +
                dec2(r_set_time[7:0]);
        m_cnt = 0;
      end else if (r_ena) begin
        if (m_cnt == int'(TICK_DIV) - 1) begin
          m_cnt = 0;
          m_tod = (m_tod + 1) % 86400;
          pulse = 1'b1;
          fire  = r_alarm_en && (m_tod == m_alarm * 60);
        end else begin
          m_cnt++;
        end
      end
      if (av) m_alarm = dec2(r_alarm_hhmm[15:8]) * 60 + dec2(r_alarm_hhmm[7:0]);
      m_irq = fire || (m_irq && !r_alarm_ack);
    end
    h = m_tod / 3600;
    e.hh        = r_mode ? to_bcd(h) : to_bcd((h % 12 == 0) ? 12 : h % 12);
    e.mm        = to_bcd((m_tod / 60) % 60);
    e.ss        = to_bcd(m_tod % 60);
    e.pm        = (h >= 12);
    e.sec_pulse = pulse;
    e.set_err   = err;
    e.alarm_irq = m_irq;
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_set(input logic [23:0] t);
    r_set_valid = 1'b1; r_set_time = t;
    step();
    r_set_valid = 1'b0;
  endtask

  // Monitor: compare DUT outputs right after each edge with the queued prediction
  initial begin
    obs_t e, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {bus.hh, bus.mm, bus.ss, bus.pm, bus.sec_pulse, bus.set_err, bus.alarm_irq};
        compared++;
        if (got !== e) begin
          mismatched++;
          $display("FAIL outputs t=%0t: got hh=%h mm=%h ss=%h pm=%b pulse=%b err=%b irq=%b, required hh=%h mm=%h ss=%h pm=%b pulse=%b err=%b irq=%b",
                   $time, got.hh, got.mm, got.ss, got.pm, got.sec_pulse, got.set_err,
                   got.alarm_irq, e.hh, e.mm, e.ss, e.pm, e.sec_pulse, e.set_err, e.alarm_irq);
        end
      end
    end
  end

  initial begin
    int waited;
    clear_stim();
    r_mode = 1'b0; r_alarm_en = 1'b0;
    bus.ena = 1'b0; bus.mode_24h = 1'b0; bus.set_valid = 1'b0; bus.set_time = '0;
    bus.alarm_wr = 1'b0; bus.alarm_hhmm = '0; bus.alarm_en = 1'b0; bus.alarm_ack = 1'b0;

    // Reset in both display modes
    r_reset = 1'b1; run(2);
    r_mode = 1'b1; run(1);
    r_mode = 1'b0; run(1);
    r_reset = 1'b0;

    // Prescaler holds while ena is low; tick on the 4th enabled cycle
    r_ena = 1'b1; run(2);
    r_ena = 1'b0; run(1);
    r_ena = 1'b1; run(2);
    r_ena = 1'b0; run(1);

    // Hour rollovers and 12-hour display
    do_set(t24(11, 59, 59)); r_ena = 1'b1; run(4); r_ena = 1'b0;
    do_set(t24(23, 59, 59)); r_ena = 1'b1; run(4); r_ena = 1'b0;
    r_mode = 1'b1; run(1);
    r_mode = 1'b0; do_set(t24(13, 5, 0)); run(1);

    // Rejected writes leave time and alarm alone
    do_set(24'h240000);
    do_set(24'h125A00);
    r_alarm_wr = 1'b1; r_alarm_hhmm = 16'h1260; step(); r_alarm_wr = 1'b0;
    run(1);

    // Alarm fire, hold, ack; set onto alarm time and disabled alarm do not fire
    r_alarm_en = 1'b1;
    r_alarm_wr = 1'b1; r_alarm_hhmm = 16'h0730;
    do_set(t24(7, 29, 59)); r_alarm_wr = 1'b0;
    r_ena = 1'b1; run(4); r_ena = 1'b0; run(3);
    r_alarm_ack = 1'b1; step(); r_alarm_ack = 1'b0; run(1);
    do_set(t24(7, 30, 0)); r_ena = 1'b1; run(4); r_ena = 1'b0;
    r_alarm_en = 1'b0;
    do_set(t24(7, 29, 59)); r_ena = 1'b1; run(4);

    // Set coincident with a tick, then reset overriding a set
    do_set(t24(1, 2, 3)); run(3);
    do_set(t24(5, 0, 0)); run(2);
    r_reset = 1'b1; r_set_valid = 1'b1; r_set_time = t24(9, 9, 9); step();
    r_reset = 1'b0; r_set_valid = 1'b0; run(2);

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      clear_stim();
      r_reset = ($urandom_range(0, 499) == 0);
      r_ena   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) r_mode = ~r_mode;
      if ($urandom_range(0, 39) == 0) begin
        r_set_valid = 1'b1;
        if ($urandom_range(0, 3) == 0) r_set_time = 24'($urandom);
        else r_set_time = t24($urandom_range(0, 23),
                              $urandom_range(0, 1) ? 59 : $urandom_range(0, 59),
                              $urandom_range(55, 59));
      end
      if ($urandom_range(0, 59) == 0) begin
        r_alarm_wr = 1'b1;
        if ($urandom_range(0, 4) == 0) r_alarm_hhmm = 16'($urandom);
        else r_alarm_hhmm = {to_bcd(((m_tod / 60 + 1) % 1440) / 60),
                             to_bcd(((m_tod / 60 + 1) % 1440) % 60)};
      end
      if ($urandom_range(0, 99) == 0) r_alarm_en = ~r_alarm_en;
      r_alarm_ack = ($urandom_range(0, 29) == 0);
      step();
    end

    clear_stim();
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      mismatched++;
      $display("FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
